// File: rtl/st_aligner_pkg.sv
// Shared store-path definitions: SB/SH/SW funct3 codes, FSM state encoding
// and the funct3 -> byte-mask helper used by both the FSM and the lane generator.
package st_aligner_pkg;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WR_LO = 2'b01,
        WR_HI = 2'b10
    } st_state_e;

    // An all-zero mask marks an illegal funct3.
    function automatic logic [3:0] st_mask(input logic [2:0] funct3);
        case (funct3)
            F3_SB:   return 4'b0001;
            F3_SH:   return 4'b0011;
            F3_SW:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/st_aligner_lane.sv
// st_lane_gen: positions store data and byte strobes across a 64-bit window
// spanning the addressed word and the word after it.
module st_lane_gen
    import st_aligner_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] data,
    output logic [63:0] lane_data,
    output logic [7:0]  lane_strb,
    output logic        illegal
);

    logic [3:0]  mask;
    logic [31:0] data_m;

    // NOTE: every output of a combinational block is assigned on every path,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        mask      = st_mask(funct3);
        data_m    = data & {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
        lane_data = {32'b0, data_m} << {off, 3'b000};
        lane_strb = {4'b0000, mask} << off;
        illegal   = (mask == 4'b0000);
    end

endmodule

// File: rtl/st_aligner.sv
// MEM-stage store unit: turns SB/SH/SW into word-aligned strobed writes over a
// valid/ack interface, splitting word-crossing stores when ALLOW_MISALIGNED=1.
module st_aligner
    import st_aligner_pkg::*;
#(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    input  logic [2:0]  st_funct3,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_ready,
    output logic        st_done,
    output logic        st_misaligned,
    output logic        st_illegal,
    output logic        stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack
);

    st_state_e   state_q, state_d;
    logic [31:0] addr_q, data_q, word_addr;
    logic [2:0]  funct3_q;
    logic        reject_q, done_q, done_d;
    logic [63:0] lane_data;
    logic [7:0]  lane_strb;
    logic        lane_illegal;
    logic        accept, in_illegal, in_cross, in_reject;
    logic [3:0]  in_mask;

    st_lane_gen u_lane (
        .funct3    (funct3_q),
        .off       (addr_q[1:0]),
        .data      (data_q),
        .lane_data (lane_data),
        .lane_strb (lane_strb),
        .illegal   (lane_illegal)
    );

    // Legality and crossing are decided on the live request so a legal store
    // can raise mem_req the very next cycle.
    assign accept     = st_valid && (state_q == IDLE);
    assign in_mask    = st_mask(st_funct3);
    assign in_illegal = (in_mask == 4'b0000);
    assign in_cross   = ({4'b0000, in_mask} << st_addr[1:0]) > 8'h0F;
    assign in_reject  = in_illegal || (in_cross && !ALLOW_MISALIGNED);

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE:  if (accept && !in_reject) state_d = WR_LO;
            WR_LO: if (mem_ack) begin
                if (lane_strb > 8'h0F) begin
                    state_d = WR_HI;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            WR_HI: if (mem_ack) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            funct3_q <= '0;
            reject_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            reject_q <= accept && in_reject;
            done_q   <= done_d;
            if (accept) begin
                addr_q   <= st_addr;
                data_q   <= st_data;
                funct3_q <= st_funct3;
            end
        end
    end

    assign word_addr = {addr_q[31:2], 2'b00};

    assign st_ready      = (state_q == IDLE);
    assign stall         = st_valid && !st_ready;
    assign st_done       = done_q;
    assign st_illegal    = reject_q && lane_illegal;
    assign st_misaligned = reject_q && !lane_illegal;

    // Write fields come straight from captured registers, so they cannot move
    // while a write waits for its ack; they read zero when no write is open.
    assign mem_req   = (state_q != IDLE);
    assign mem_addr  = !mem_req ? '0 : (state_q == WR_HI) ? word_addr + 32'd4 : word_addr;
    assign mem_wdata = !mem_req ? '0 : (state_q == WR_HI) ? lane_data[63:32] : lane_data[31:0];
    assign mem_wstrb = !mem_req ? '0 : (state_q == WR_HI) ? lane_strb[7:4] : lane_strb[3:0];

endmodule

// File: tb/tb_st_aligner.sv
// Scoreboard bench for st_aligner: directed stores push expected writes and
// completion events; a negedge monitor compares whatever the DUT presents.
module tb_st_aligner;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } wr_t;

    localparam logic [2:0] EV_DONE = 3'b001;
    localparam logic [2:0] EV_MIS  = 3'b010;
    localparam logic [2:0] EV_ILL  = 3'b100;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid, st_valid_b;
    logic [2:0]  st_funct3;
    logic [31:0] st_addr, st_data;
    logic        st_ready, st_done, st_misaligned, st_illegal, stall;
    logic        mem_req, mem_ack;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        st_ready_b, st_done_b, st_misaligned_b, st_illegal_b, stall_b;
    logic        mem_req_b, mem_ack_b;
    logic [31:0] mem_addr_b, mem_wdata_b;
    logic [3:0]  mem_wstrb_b;

    int checks = 0;
    int errors = 0;
    int ack_wait = 0;
    bit ack_block = 0;
    bit ack_force = 0;

    wr_t        exp_wr_q[$];
    logic [2:0] exp_ev_q[$];

    always #5 clk = ~clk;

    st_aligner #(.ALLOW_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst(rst), .st_valid(st_valid), .st_funct3(st_funct3),
        .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready), .st_done(st_done),
        .st_misaligned(st_misaligned), .st_illegal(st_illegal), .stall(stall),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ack(mem_ack)
    );

    st_aligner #(.ALLOW_MISALIGNED(1'b0)) dut_b (
        .clk(clk), .rst(rst), .st_valid(st_valid_b), .st_funct3(st_funct3),
        .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready_b), .st_done(st_done_b),
        .st_misaligned(st_misaligned_b), .st_illegal(st_illegal_b), .stall(stall_b),
        .mem_req(mem_req_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_wstrb(mem_wstrb_b), .mem_ack(mem_ack_b)
    );

    assign mem_ack_b = mem_req_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Memory model: ack after ack_wait low cycles of mem_req, driven mid-cycle.
    initial begin
        int cnt = 0;
        mem_ack = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (ack_force) begin
                mem_ack = 1'b1;
            end else if (mem_req && !rst && !ack_block) begin
                mem_ack = (cnt >= ack_wait);
                cnt = mem_ack ? 0 : cnt + 1;
            end else begin
                mem_ack = 1'b0;
                cnt = 0;
            end
        end
    end

    // Monitor: every cycle with mem_req is compared against the head of the
    // expected-write queue, popped on ack; any completion pulse pops an event.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_req) begin
                    if (exp_wr_q.size() == 0) begin
                        fail_now("unexpected_write");
                    end else begin
                        e = exp_wr_q[0];
                        check("wr_addr", mem_addr, e.addr);
                        check("wr_wdata", mem_wdata, e.wdata);
                        check("wr_wstrb", {28'b0, mem_wstrb}, {28'b0, e.strb});
                        if (mem_ack) void'(exp_wr_q.pop_front());
                    end
                end
                if (st_done || st_misaligned || st_illegal) begin
                    if (exp_ev_q.size() == 0)
                        fail_now("unexpected_event");
                    else
                        check("event", {29'b0, st_illegal, st_misaligned, st_done},
                              {29'b0, exp_ev_q.pop_front()});
                end
            end
        end
    end

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        st_funct3 = f3;
        st_addr   = a;
        st_data   = d;
        st_valid  = 1'b1;
        @(negedge clk);
        while (!st_ready && n < 50) begin
            check("stall_while_busy", {31'b0, stall}, 32'd1);
            n++;
            @(negedge clk);
        end
        if (!st_ready) fail_now("accept_timeout");
        @(posedge clk);
        #1 st_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_wr_q.size() != 0 || exp_ev_q.size() != 0 || !st_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            fail_now("drain_timeout");
            exp_wr_q.delete();
            exp_ev_q.delete();
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic b_case(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic exp_mis, input logic exp_ill, input logic exp_wr);
        st_funct3  = f3;
        st_addr    = a;
        st_data    = 32'hCAFE_F00D;
        st_valid_b = 1'b1;
        @(posedge clk);
        #1 st_valid_b = 1'b0;
        @(negedge clk);
        check({name, "_mis"}, {31'b0, st_misaligned_b}, {31'b0, exp_mis});
        check({name, "_ill"}, {31'b0, st_illegal_b}, {31'b0, exp_ill});
        check({name, "_req"}, {31'b0, mem_req_b}, {31'b0, exp_wr});
        @(negedge clk);
        check({name, "_pulse_end"}, {30'b0, st_misaligned_b, st_illegal_b}, 32'd0);
        check({name, "_done"}, {31'b0, st_done_b}, {31'b0, exp_wr});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        st_valid = 1'b0;
        st_valid_b = 1'b0;
        st_funct3 = 3'b000;
        st_addr = '0;
        st_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'b0, st_ready}, 32'd1);
        check("rst_outs", {27'b0, st_done, st_misaligned, st_illegal, stall, mem_req}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_wstrb", {28'b0, mem_wstrb}, 32'd0);
        @(posedge clk);
        #1;

        // Aligned SW, immediate ack: mem_req in cycle 1, st_done in cycle 2.
        exp_wr_q.push_back('{32'h0000_0100, 32'hDEAD_BEEF, 4'b1111});
        exp_ev_q.push_back(EV_DONE);
        issue(3'b010, 32'h0000_0100, 32'hDEAD_BEEF);
        @(negedge clk);
        check("lat_req_c1", {30'b0, mem_req, st_done}, 32'd2);
        @(negedge clk);
        check("lat_done_c2", {30'b0, mem_req, st_done}, 32'd1);
        drain();

        // SB into lane 3, upper data bits discarded.
        exp_wr_q.push_back('{32'h0000_0200, 32'hA500_0000, 4'b1000});
        exp_ev_q.push_back(EV_DONE);
        issue(3'b000, 32'h0000_0203, 32'h1234_56A5);
        drain();

        // SH at offset 3 splits across two words; only one st_done.
        exp_wr_q.push_back('{32'h0000_00FC, 32'hEF00_0000, 4'b1000});
        exp_wr_q.push_back('{32'h0000_0100, 32'h0000_00BE, 4'b0001});
        exp_ev_q.push_back(EV_DONE);
        issue(3'b001, 32'h0000_00FF, 32'hCAFE_BEEF);
        drain();

        // Illegal funct3: pulse only, no write.
        exp_ev_q.push_back(EV_ILL);
        issue(3'b011, 32'h0000_0010, 32'h0000_0055);
        drain();

        // Slow memory: SW waits 5 cycles with fields held; an SB presented
        // meanwhile is held off and accepted only once the SW has completed.
        ack_wait = 5;
        exp_wr_q.push_back('{32'h0000_0040, 32'h1122_3344, 4'b1111});
        exp_wr_q.push_back('{32'h0000_0040, 32'h0000_7700, 4'b0010});
        exp_ev_q.push_back(EV_DONE);
        exp_ev_q.push_back(EV_DONE);
        issue(3'b010, 32'h0000_0040, 32'h1122_3344);
        issue(3'b000, 32'h0000_0041, 32'hFFFF_FF77);
        drain();
        ack_wait = 0;

        // mem_ack with no request open is ignored.
        ack_force = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_ack_ignored", {30'b0, mem_req, st_done}, 32'd0);
        end
        ack_force = 1'b0;
        @(posedge clk);
        #1;

        // Split SW at the top of memory, high word wraps to address 0.
        exp_wr_q.push_back('{32'hFFFF_FFFC, 32'hC3D4_0000, 4'b1100});
        exp_wr_q.push_back('{32'h0000_0000, 32'h0000_A1B2, 4'b0011});
        exp_ev_q.push_back(EV_DONE);
        issue(3'b010, 32'hFFFF_FFFE, 32'hA1B2_C3D4);
        drain();

        // Same store, reset while the high word is pending: no st_done.
        exp_wr_q.push_back('{32'hFFFF_FFFC, 32'hC3D4_0000, 4'b1100});
        exp_wr_q.push_back('{32'h0000_0000, 32'h0000_A1B2, 4'b0011});
        issue(3'b010, 32'hFFFF_FFFE, 32'hA1B2_C3D4);
        @(posedge clk);
        #1 ack_block = 1'b1;
        @(negedge clk);
        check("hi_pending_req", {31'b0, mem_req}, 32'd1);
        check("hi_pending_strb", {28'b0, mem_wstrb}, 32'd3);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        ack_block = 1'b0;
        exp_wr_q.delete();
        @(negedge clk);
        check("post_rst_req", {31'b0, mem_req}, 32'd0);
        check("post_rst_ready", {31'b0, st_ready}, 32'd1);
        repeat (3) begin
            check("post_rst_no_done", {31'b0, st_done}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;

        // Instance without misaligned support.
        b_case("b_sw_x", 3'b010, 32'h0000_0102, 1'b1, 1'b0, 1'b0);
        b_case("b_sh_x", 3'b001, 32'h0000_00FF, 1'b1, 1'b0, 1'b0);
        b_case("b_ill",  3'b111, 32'h0000_0100, 1'b0, 1'b1, 1'b0);
        b_case("b_sh_ok", 3'b001, 32'h0000_0102, 1'b0, 1'b0, 1'b1);

        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
